regfile_dump: RTL

//  Debug reader on the spare read port of the 32x32 register file. On start it walks

---
 rtl/regfile_dump.sv | 81 ++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file read port and streams each register as an address+data byte record, then 0xFF
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              skip_zero_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [5:0]        rec_cnt_o
);
  localparam int NB = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, READ, SEND, TERM} state_t;
  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] data;
  logic [3:0]        bidx;
  logic              skip;
  logic              last;
  assign last       = idx == ADDR_W'(NUM_REGS - 1);
  assign rf_addr_o  = idx;
  assign busy_o     = state != IDLE;
  assign tx_valid_o = state == SEND || state == TERM;
  always_comb
    tx_data_o = state == TERM ? 8'hFF :
                state != SEND ? 8'h00 :
                bidx == 4'd0  ? 8'(idx) : data[7:0];
  // data is shifted down after each data byte so the next byte always sits in data[7:0]
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      idx       <= '0;
      data      <= '0;
      bidx      <= '0;
      skip      <= 1'b0;
      done_o    <= 1'b0;
      rec_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state     <= READ;
          idx       <= '0;
          skip      <= skip_zero_i;
          rec_cnt_o <= '0;
        end
        READ: begin
          data <= rf_data_i;
          bidx <= '0;
          if (skip && rf_data_i == '0) begin
            if (last) state <= TERM;
            else idx <= idx + 1'b1;
          end else state <= SEND;
        end
        SEND: if (tx_ready_i) begin
          if (bidx != 4'd0) data <= data >> 8;
          if (bidx == 4'(NB)) begin
            rec_cnt_o <= rec_cnt_o + 6'd1;
            if (last) state <= TERM;
            else begin
              state <= READ;
              idx   <= idx + 1'b1;
            end
          end else bidx <= bidx + 4'd1;
        end
        TERM: if (tx_ready_i) begin
          state  <= IDLE;
          done_o <= 1'b1;
        end
      endcase
    end
  end
endmodule
